// File: rtl/bool_tt_sweeper.sv
// Sweeps {a,b,c} through 0..7 into a boolean stage, captures e into a truth table, compares to EXPECTED_TT.
// Latency: SETTLE_CYCLES+1 cycles per vector; done pulses 8*(SETTLE_CYCLES+1)+1 cycles after start accept.
// Backpressure: none; start is honoured only in IDLE and dropped otherwise. Optional err_cnt via BOOL_TT_ERRCNT_EN.
module bool_tt_sweeper #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECTED_TT   = 8'h57
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] abc,
    input  logic       e_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
`ifdef BOOL_TT_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       tt_pass;

    assign tt_pass = (truth_table == EXPECTED_TT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (idx == 3'd7) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The done pulse and the compare result are both registered on the DONE exit edge,
    // so the table already holds the bit-7 sample when compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc         <= 3'd0;
            idx         <= 3'd0;
            cnt         <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 8'h00;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        abc         <= 3'd0;
                        idx         <= 3'd0;
                        cnt         <= 4'd0;
                        busy        <= 1'b1;
                        truth_table <= 8'h00;
                        match       <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                end
                SAMPLE: begin
                    truth_table[idx] <= e_in;
                    if (idx == 3'd7) begin
                        busy <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                        abc <= idx + 3'd1;
                        cnt <= 4'd0;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    match <= tt_pass;
                end
                default: ;
            endcase
        end
    end

`ifdef BOOL_TT_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (state == DONE && !tt_pass && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/bool_tt_sweeper.md
Name: bool_tt_sweeper

Overview:
- Upstream driver and downstream checker for the 3-input boolean stage `e = ~((a|b)&c)`.
- On a start pulse it drives all 8 input combinations onto {a,b,c} in ascending order and waits a fixed number of settle cycles per vector.
- It samples the stage output `e` and assembles an 8-bit truth table, then compares that table against an expected constant.
- Used as the lab self-check harness that wraps the combinational boolean blocks.

Parameters:
- SETTLE_CYCLES, 2, cycles abc is held before e_in is sampled; legal range 1..15.
- EXPECTED_TT, 8'h57, expected truth table, bit i = e for {a,b,c}=i; 8'h57 is the table of ~((a|b)&c).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep; accepted only in IDLE.
- abc  out  3  registered drive to the boolean stage: abc[2]=a, abc[1]=b, abc[0]=c.
- e_in  in  1  output e of the boolean stage under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- truth_table  out  8  captured table, bit i = e_in sampled while abc=i.
- match  out  1  truth_table==EXPECTED_TT; valid from done, held until the next start.
- err_cnt  out  8  failed-sweep count; present only with BOOL_TT_ERRCNT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, abc=0, busy=0, done=0, truth_table=0, match=0, idx=0, settle counter=0, err_cnt=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge moves to SETTLE.
  - At the same edge: abc<=0, idx<=0, cnt<=0, busy<=1, truth_table<=0, match<=0.
- SETTLE:
  - abc holds idx; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - At the closing edge, truth_table[idx]<=e_in.
  - If idx==7, go to DONE.
  - Otherwise idx<=idx+1, abc<=idx+1, cnt<=0, go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, match<=(final truth_table==EXPECTED_TT); the compare uses the table including the bit-7 sample.
  - Next edge returns to IDLE with done=0.
- Outputs: busy, done and match are registered. abc stays at 7 after the sweep until the next start.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - The done pulse appears 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge: 25 cycles for SETTLE_CYCLES=2.
- Idle outputs: truth_table and match hold their last values through IDLE.
- start while busy or in DONE: ignored, with no queueing and no restart.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- idx is 3 bits; the idx==7 check terminates the sweep, and no wrap past 7 is permitted.
- Reset mid-sweep: immediate return to reset values; no done pulse, and the partial table is discarded.
- e_in is sampled only in SAMPLE; e_in changes in any other state have no effect.

Optional Feature:
- Macro: BOOL_TT_ERRCNT_EN.
- When defined:
  - Port err_cnt[7:0] exists.
  - In DONE, if the compare fails, err_cnt increments, saturating at 8'hFF; it does not change on a pass.
  - err_cnt clears only on reset.
- When undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> abc=0, busy=0, done=0, truth_table=8'h00, match=0 for 20 cycles.
- Correct DUT: bool stage wired to e_in, SETTLE_CYCLES=2, start pulse -> busy high 24 cycles, abc steps 0..7 every 3 cycles, done pulse 25 cycles after accept, truth_table=8'h57, match=1.
- Stuck-at fault: e_in tied to 1 -> truth_table=8'hFF, match=0; with BOOL_TT_ERRCNT_EN, err_cnt 0->1, and three more failing sweeps -> 4.
- Start while busy: second start pulse 5 cycles into the sweep -> ignored, single done pulse at the original time, abc sequence uninterrupted.
- Reset mid-sweep: assert rst_n at abc=4 -> same cycle busy=0, abc=0, truth_table=0, no done pulse; a new start then completes normally with 8'h57.
- Saturation: with BOOL_TT_ERRCNT_EN and e_in=0, run 256 failing sweeps -> err_cnt reaches 8'hFF and stays 8'hFF on the 257th.
